// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial, LSB-first adder. One operand pair (a, b, cin) is accepted per
//   transaction. The bits then pass one per clock through a single full-adder
//   slice that has a registered carry. The result {cout, sum} is offered on a
//   valid/ready output port.
//
//   Optional feature macro: SERIAL_ADD_OVF_EN
//     When defined, the block adds an ovf output that flags two's-complement
//     overflow. It is registered alongside cout.
//     When undefined, the port and its logic are absent.
//
//   Timing: operands are accepted at edge T. out_valid rises after edge
//   T+WIDTH. A result handshake at edge R raises in_ready after edge R.
//   Transactions never overlap.
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    // Bit counter sized so that it never wraps inside one transaction.
    localparam int                CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    // FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             carry;

    // Operand and partial-sum shift registers. These carry data only, so
    // they are not reset. Their contents never reach the ports directly.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] sum_nxt;
    logic             last_bit;
    logic             accept;
    logic             release_res;

    // Full-adder sum output for one bit slice.
    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    // Full-adder carry output (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Single-bit adder slice, next partial sum, and handshake qualifiers.
    always_comb begin
        bit_s       = fa_sum(a_sh[0], b_sh[0], carry);
        bit_c       = fa_carry(a_sh[0], b_sh[0], carry);
        // The new bit enters at the MSB. After WIDTH shifts, bit 0 lines up.
        sum_nxt     = sum_sh >> 1;
        sum_nxt[WIDTH-1] = bit_s;
        last_bit    = (count == LAST);
        accept      = in_valid && in_ready && (state == IDLE);
        release_res = out_valid && out_ready && (state == DONE);
    end

    // Control FSM, registered handshake flags and held result registers.
    // in_ready comes from a register, so it stays low while reset is
    // asserted. It does not depend combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry    <= cin;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ADD: begin
                    carry <= bit_c;
                    count <= count + CNT_W'(1);
                    if (last_bit) begin
                        // Here carry is the carry into the MSB and bit_c is
                        // the carry out of the MSB.
                        sum       <= sum_nxt;
                        cout      <= bit_c;
`ifdef SERIAL_ADD_OVF_EN
                        ovf       <= carry ^ bit_c;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (release_res) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf       <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Operand capture and right-shift datapath. It runs only on accept or
    // during ADD.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state == ADD) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder. It uses one WIDTH=8 instance and one
//   WIDTH=3 instance. Inputs are driven and outputs are sampled on the
//   falling clock edge.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, cin3, cout3;
    logic [2:0] a3, b3, sum3;

`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf3;
`endif

    int n_vec = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
        .cout(cout8), .ovf(ovf8)
`else
        .cout(cout8)
`endif
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .cin(cin3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .sum(sum3),
`ifdef SERIAL_ADD_OVF_EN
        .cout(cout3), .ovf(ovf3)
`else
        .cout(cout3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one operand pair to the 8-bit instance. Call at a negedge;
    // returns at the negedge after the accepting edge.
    task automatic start8(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
        int n;
        n = 0;
        while (!in_ready8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) check("start8_timeout", 32'd0, 32'd1);
        a8 = xa; b8 = xb; cin8 = xc; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    // Count negedges until out_valid is seen (bounded).
    task automatic wait_done8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid8) check("done8_timeout", 32'd0, 32'd1);
    endtask

    // Accept the result and confirm the block returns to idle.
    task automatic retire8();
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check("in_ready_after_ack", in_ready8, 1'b1);
        check("out_valid_after_ack", out_valid8, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf_after_ack", ovf8, 1'b0);
`endif
    endtask

    initial begin
        int lat;
        int spurious;
        logic [3:0] exp3;
        logic [7:0] hold_sum;
        logic       hold_cout;

        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready8", in_ready8, 1'b0);
        check("rst_out_valid8", out_valid8, 1'b0);
        check("rst_sum8", sum8, 8'd0);
        check("rst_cout8", cout8, 1'b0);
        check("rst_in_ready3", in_ready3, 1'b0);
        check("rst_out_valid3", out_valid3, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf8", ovf8, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready8", in_ready8, 1'b1);
        check("idle_in_ready3", in_ready3, 1'b1);

        // 3 + 5 with out_ready already high
        out_ready8 = 1'b1;
        start8(8'd3, 8'd5, 1'b0);
        wait_done8(lat);
        check("t1_latency", lat, 8);
        check("t1_sum", sum8, 8'd8);
        check("t1_cout", cout8, 1'b0);
        retire8();

        // Boundary vectors
        start8(8'd255, 8'd1, 1'b0);
        wait_done8(lat);
        check("t2a_latency", lat, 8);
        check("t2a_sum", sum8, 8'd0);
        check("t2a_cout", cout8, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        check("t2a_ovf", ovf8, 1'b0);
`endif
        retire8();

        start8(8'd127, 8'd1, 1'b0);
        wait_done8(lat);
        check("t2b_sum", sum8, 8'd128);
        check("t2b_cout", cout8, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check("t2b_ovf", ovf8, 1'b1);
`endif
        retire8();

        start8(8'd255, 8'd255, 1'b1);
        wait_done8(lat);
        check("t2c_latency", lat, 8);
        check("t2c_sum", sum8, 8'd255);
        check("t2c_cout", cout8, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        check("t2c_ovf", ovf8, 1'b0);
`endif
        retire8();

        // Backpressure: 200 + 100 = 300 -> sum 44, cout 1
        start8(8'd200, 8'd100, 1'b0);
        wait_done8(lat);
        check("t3_sum", sum8, 8'd44);
        check("t3_cout", cout8, 1'b1);
        hold_sum = sum8;
        hold_cout = cout8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", out_valid8, 1'b1);
            check("t3_hold_sum", sum8, 8'd44);
            check("t3_hold_cout", cout8, 1'b1);
            check("t3_hold_in_ready", in_ready8, 1'b0);
        end
        retire8();

        // Busy ignore: second operand pulse during ADD
        start8(8'd3, 8'd5, 1'b0);
        check("t4_busy_in_ready", in_ready8, 1'b0);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; cin8 = 1'b1; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        wait_done8(lat);
        check("t4_latency", lat + 2, 8);
        check("t4_sum", sum8, 8'd8);
        check("t4_cout", cout8, 1'b0);
        retire8();

        // Reset during the third ADD cycle
        start8(8'd100, 8'd27, 1'b1);
        repeat (2) @(negedge clk);
        check("t5_sum_hidden", sum8, 8'd8);
        rst_n = 1'b0;
        #1;
        check("t5_rst_sum", sum8, 8'd0);
        check("t5_rst_cout", cout8, 1'b0);
        check("t5_rst_out_valid", out_valid8, 1'b0);
        check("t5_rst_in_ready", in_ready8, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid8) spurious++;
        end
        check("t5_no_spurious", spurious, 0);
        check("t5_in_ready", in_ready8, 1'b1);
        check("t5_sum_after", sum8, 8'd0);

        // WIDTH=3 exhaustive, back to back
        out_ready3 = 1'b1;
        for (int i = 0; i < 128; i++) begin
            int n;
            n = 0;
            while (!in_ready3 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready3) check("w3_start_timeout", 32'd0, 32'd1);
            a3 = i[2:0]; b3 = i[5:3]; cin3 = i[6];
            exp3 = {1'b0, a3} + {1'b0, b3} + {3'b000, cin3};
            in_valid3 = 1'b1;
            @(negedge clk);
            in_valid3 = 1'b0;
            n = 0;
            while (!out_valid3 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid3) check("w3_done_timeout", 32'd0, 32'd1);
            check("w3_latency", n, 3);
            check("w3_add", {cout3, sum3}, exp3);
        end
        out_ready3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
